// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes a MIPS-format instruction and holds the result
// in a single-entry valid/ready pipeline register.
module alu_issue_stage #(
    parameter bit NOP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_alu_ctrl,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic        out_alu_src,
    output logic        out_reg_write,
    output logic        out_branch,
    output logic        out_illegal
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef struct packed {
        logic        valid;
        logic [2:0]  alu_ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alu_src;
        logic        reg_write;
        logic        branch;
        logic        illegal;
    } entry_t;

    entry_t dec;
    entry_t ent_d;
    entry_t ent_q;

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = in_instr[31:26];
    assign funct = in_instr[5:0];

    always_comb begin
        dec           = '0;
        dec.valid     = 1'b1;
        dec.rs        = in_instr[25:21];
        dec.rt        = in_instr[20:16];
        dec.rd        = (op == 6'h00) ? in_instr[15:11] : in_instr[20:16];
        dec.imm       = {{16{in_instr[15]}}, in_instr[15:0]};
        dec.reg_write = 1'b1;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20: dec.alu_ctrl = ALU_ADD;
                    6'h22: dec.alu_ctrl = ALU_SUB;
                    6'h24: dec.alu_ctrl = ALU_AND;
                    6'h25: dec.alu_ctrl = ALU_OR;
                    default: dec.illegal = 1'b1;
                endcase
            end
            6'h08: begin
                dec.alu_ctrl = ALU_ADD;
                dec.alu_src  = 1'b1;
            end
            6'h0C: begin
                dec.alu_ctrl = ALU_AND;
                dec.alu_src  = 1'b1;
                dec.imm      = {16'h0000, in_instr[15:0]};
            end
            6'h0D: begin
                dec.alu_ctrl = ALU_OR;
                dec.alu_src  = 1'b1;
                dec.imm      = {16'h0000, in_instr[15:0]};
            end
            6'h04: begin
                dec.alu_ctrl  = ALU_SUB;
                dec.reg_write = 1'b0;
                dec.branch    = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.alu_ctrl = ALU_ADD;
            if (NOP_ON_ILLEGAL) begin
                dec.reg_write = 1'b0;
                dec.branch    = 1'b0;
            end
        end
    end

    assign in_ready = !ent_q.valid || out_ready;

    // Flush only kills valid; stale data fields are don't-care while empty.
    always_comb begin
        ent_d = ent_q;
        if (flush) begin
            ent_d.valid = 1'b0;
        end else if (in_valid && in_ready) begin
            ent_d = dec;
        end else if (ent_q.valid && out_ready) begin
            ent_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    assign out_valid     = ent_q.valid;
    assign out_alu_ctrl  = ent_q.alu_ctrl;
    assign out_rs        = ent_q.rs;
    assign out_rt        = ent_q.rt;
    assign out_rd        = ent_q.rd;
    assign out_imm       = ent_q.imm;
    assign out_alu_src   = ent_q.alu_src;
    assign out_reg_write = ent_q.reg_write;
    assign out_branch    = ent_q.branch;
    assign out_illegal   = ent_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage with hand-computed expectations.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_alu_ctrl;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_alu_src;
    logic        out_reg_write;
    logic        out_branch;
    logic        out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(in_valid),
        .in_instr(in_instr),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_alu_ctrl(out_alu_ctrl),
        .out_rs(out_rs),
        .out_rt(out_rt),
        .out_rd(out_rd),
        .out_imm(out_imm),
        .out_alu_src(out_alu_src),
        .out_reg_write(out_reg_write),
        .out_branch(out_branch),
        .out_illegal(out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b1;
        step();
        in_valid = 1'b1;
        in_instr = 32'h012A4020;
        step();
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_ctrl", {29'b0, out_alu_ctrl}, 0);
        check("rst_rd", {27'b0, out_rd}, 0);
        check("rst_imm", out_imm, 0);
        check("rst_rw", {31'b0, out_reg_write}, 0);
        check("rst_inrdy", {31'b0, in_ready}, 1);

        // ADD r8, r9, r10 on the first cycle after reset
        rst = 1'b0;
        step();
        check("add_valid", {31'b0, out_valid}, 1);
        check("add_ctrl", {29'b0, out_alu_ctrl}, 0);
        check("add_rs", {27'b0, out_rs}, 9);
        check("add_rt", {27'b0, out_rt}, 10);
        check("add_rd", {27'b0, out_rd}, 8);
        check("add_src", {31'b0, out_alu_src}, 0);
        check("add_rw", {31'b0, out_reg_write}, 1);
        check("add_imm", out_imm, 32'h00004020);

        in_instr = 32'h2128FFFF;
        step();
        check("addi_valid", {31'b0, out_valid}, 1);
        check("addi_imm", out_imm, 32'hFFFFFFFF);
        check("addi_ctrl", {29'b0, out_alu_ctrl}, 0);
        check("addi_rd", {27'b0, out_rd}, 8);
        check("addi_src", {31'b0, out_alu_src}, 1);

        in_instr = 32'h3528FFFF;
        step();
        check("ori_valid", {31'b0, out_valid}, 1);
        check("ori_imm", out_imm, 32'h0000FFFF);
        check("ori_ctrl", {29'b0, out_alu_ctrl}, 3);
        check("ori_rd", {27'b0, out_rd}, 8);

        in_instr = 32'h112A0004;
        step();
        check("beq_ctrl", {29'b0, out_alu_ctrl}, 1);
        check("beq_br", {31'b0, out_branch}, 1);
        check("beq_rw", {31'b0, out_reg_write}, 0);
        check("beq_imm", out_imm, 32'h00000004);
        check("beq_src", {31'b0, out_alu_src}, 0);

        in_instr = 32'h012A4022;
        step();
        check("sub_ctrl", {29'b0, out_alu_ctrl}, 1);
        check("sub_br", {31'b0, out_branch}, 0);

        // stall with an AND waiting upstream
        out_ready = 1'b0;
        in_instr  = 32'h012A4024;
        #1;
        check("stall_inrdy", {31'b0, in_ready}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", {31'b0, out_valid}, 1);
            check("stall_ctrl", {29'b0, out_alu_ctrl}, 1);
            check("stall_inrdy", {31'b0, in_ready}, 0);
        end
        out_ready = 1'b1;
        #1;
        check("unstall_inrdy", {31'b0, in_ready}, 1);
        step();
        check("and_valid", {31'b0, out_valid}, 1);
        check("and_ctrl", {29'b0, out_alu_ctrl}, 2);

        in_instr = 32'hFC000000;
        step();
        check("ill_flag", {31'b0, out_illegal}, 1);
        check("ill_rw", {31'b0, out_reg_write}, 0);
        check("ill_ctrl", {29'b0, out_alu_ctrl}, 0);
        check("ill_br", {31'b0, out_branch}, 0);

        in_instr = 32'h312A8001;
        step();
        check("andi_ctrl", {29'b0, out_alu_ctrl}, 2);
        check("andi_imm", out_imm, 32'h00008001);
        check("andi_rd", {27'b0, out_rd}, 10);
        check("andi_ill", {31'b0, out_illegal}, 0);

        in_instr = 32'h012A4021;
        step();
        check("funct_ill", {31'b0, out_illegal}, 1);
        check("funct_rw", {31'b0, out_reg_write}, 0);

        in_valid = 1'b0;
        step();
        check("drain_valid", {31'b0, out_valid}, 0);
        out_ready = 1'b0;
        #1;
        check("empty_inrdy", {31'b0, in_ready}, 1);

        in_valid = 1'b1;
        in_instr = 32'h012A4024;
        step();
        check("fill_valid", {31'b0, out_valid}, 1);
        flush    = 1'b1;
        in_instr = 32'h012A4020;
        step();
        check("flush_valid", {31'b0, out_valid}, 0);
        flush     = 1'b0;
        out_ready = 1'b1;
        in_instr  = 32'h3528FFFF;
        step();
        check("post_flush", {29'b0, out_alu_ctrl}, 3);
        rst      = 1'b1;
        in_instr = 32'h012A4020;
        step();
        check("mid_rst_valid", {31'b0, out_valid}, 0);
        check("mid_rst_imm", out_imm, 0);
        check("mid_rst_rd", {27'b0, out_rd}, 0);
        check("mid_rst_src", {31'b0, out_alu_src}, 0);
        rst = 1'b0;
        step();
        check("first_after_rst", {31'b0, out_valid}, 1);
        check("first_rd", {27'b0, out_rd}, 8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Purpose: ID/EX-side producer for the ALU. It decodes a 32-bit instruction into ALU control code, operand selects and write-back controls, and registers the result behind a valid/ready pipeline handshake.

Interface
REQ-001 Parameter NOP_ON_ILLEGAL, default 1, meaning: 1 forces out_reg_write=0 and out_branch=0 for illegal instructions.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  discards any held entry and any entry being accepted this cycle.
REQ-005 in_valid  input  1  in_instr is valid.
REQ-006 in_instr  input  32  MIPS-format instruction word.
REQ-007 in_ready  output  1  stage can accept an instruction this cycle.
REQ-008 out_valid  output  1  registered decode outputs are valid.
REQ-009 out_ready  input  1  downstream EX stage accepts this cycle.
REQ-010 out_alu_ctrl  output  3  ALU code: 000=ADD, 001=SUB, 010=AND, 011=OR.
REQ-011 out_rs, out_rt, out_rd  output  5 each  source fields; out_rd = instr[15:11] for R-type, instr[20:16] for I-type.
REQ-012 out_imm  output  32  extended immediate.
REQ-013 out_alu_src  output  1  1 selects out_imm as ALU operand b; 0 selects the rt register.
REQ-014 out_reg_write, out_branch, out_illegal  output  1 each  write-back enable, BEQ marker, undecodable instruction.

Function
REQ-015 Decode table (opcode=instr[31:26], funct=instr[5:0]) SHALL be:
- op 0x00, funct 0x20: ADD, alu_src=0, reg_write=1
- op 0x00, funct 0x22: SUB, alu_src=0, reg_write=1
- op 0x00, funct 0x24: AND, alu_src=0, reg_write=1
- op 0x00, funct 0x25: OR, alu_src=0, reg_write=1
- op 0x08 (ADDI): ADD, alu_src=1, imm sign-extended, reg_write=1
- op 0x0C (ANDI): AND, alu_src=1, imm zero-extended, reg_write=1
- op 0x0D (ORI): OR, alu_src=1, imm zero-extended, reg_write=1
- op 0x04 (BEQ): SUB, alu_src=0, imm sign-extended, reg_write=0, branch=1
REQ-016 Any other opcode/funct combination SHALL set out_illegal=1 and out_alu_ctrl=000; if NOP_ON_ILLEGAL=1, reg_write=0 and branch=0.
REQ-017 For R-type, out_imm SHALL be the sign-extension of instr[15:0].
REQ-018 The stage is a single-entry pipeline register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-019 in_ready SHALL equal (!out_valid || out_ready), combinationally; no other input may affect it.
REQ-020 A transfer in occurs when in_valid && in_ready. A transfer out occurs when out_valid && out_ready.
REQ-021 Transfer in, no flush: decoded fields SHALL be registered and out_valid=1 the next cycle. Latency is 1 cycle.
REQ-022 Simultaneous transfer out and transfer in: the new entry SHALL replace the old one with no bubble, so full throughput is 1 instruction per cycle.
REQ-023 Transfer out with no transfer in: out_valid SHALL go to 0 the next cycle.
REQ-024 While FULL and out_ready=0, all out_* fields SHALL hold stable, regardless of in_valid or in_instr.
REQ-025 While EMPTY, out_* data fields are don't-care except out_valid.
REQ-026 flush=1 SHALL force out_valid=0 next cycle; the entry accepted in the same cycle is dropped. flush has priority over transfer in.
REQ-027 The stage SHALL have no internal state besides the output registers and out_valid.

Reset
REQ-028 rst=1 SHALL, at the next clock edge, clear out_valid and all out_* registers to 0; rst has priority over flush and handshakes.
REQ-029 In-flight entries at reset SHALL be lost. in_ready during reset follows REQ-019.
REQ-030 The first transfer in SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-031 in_instr=0x012A4020, in_valid=1, out_ready=1 -> next cycle out_valid=1, alu_ctrl=000, rs=9, rt=10, rd=8, alu_src=0, reg_write=1.
REQ-032 0x2128FFFF (ADDI) then 0x3528FFFF (ORI) back-to-back -> imm=0xFFFFFFFF with alu_ctrl=000, then imm=0x0000FFFF with alu_ctrl=011; rd=8 for both; no bubble.
REQ-033 0x112A0004 (BEQ) -> alu_ctrl=001, branch=1, reg_write=0, imm=0x00000004.
REQ-034 out_ready=0 for 3 cycles while FULL with 0x012A4022 and in_valid=1 -> in_ready=0, outputs frozen with alu_ctrl=001; out_ready=1 -> next instruction loads the following cycle.
REQ-035 in_instr=0xFC000000 -> out_illegal=1, reg_write=0, alu_ctrl=000.
REQ-036 flush=1 with in_valid=1 while FULL -> out_valid=0 next cycle; rst=1 mid-stream -> all outputs 0 next cycle.
